vga_fade_core: RTL



---
 rtl/vga_fade_core.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_fade_core.sv
// vga_fade_core: video slot core that blends every pixel toward a programmable
// target colour with a 5-bit alpha (0..16), stepped once per PERIOD frames.
// It runs a fade-out / hold / fade-in sequence and is write-only from the bus.
// Optional feature macro: VGA_FADE_LOOP_EN. When defined, CTRL.LOOP makes a
// finished fade-in restart the fade-out. When undefined, no LOOP logic exists.
module vga_fade_core #(
  parameter int CD         = 12,
  parameter int DEF_PERIOD = 2,
  parameter int DEF_HOLD   = 60
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT,
    S_HOLD,
    S_IN
  } state_t;

  // Configuration registers
  logic        r_bypass;
  logic [7:0]  r_period;
  logic [7:0]  r_hold;
  logic [11:0] r_target;
`ifdef VGA_FADE_LOOP_EN
  logic        r_loop;
`endif

  // Sequencer state
  state_t      r_state;
  logic [4:0]  r_alpha;
  logic [7:0]  r_fcnt;
  logic [7:0]  r_hcnt;
  logic        r_origin_d;

  // Bus decode: START is a pulse taken straight from the write strobe, so it
  // clears itself without any storage.
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_period;
  logic w_wr_hold;
  logic w_wr_target;
  logic w_start;

  assign w_wr        = cs & write;
  assign w_wr_ctrl   = w_wr && (addr[1:0] == 2'd0);
  assign w_wr_period = w_wr && (addr[1:0] == 2'd1);
  assign w_wr_hold   = w_wr && (addr[1:0] == 2'd2);
  assign w_wr_target = w_wr && (addr[1:0] == 2'd3);
  assign w_start     = w_wr_ctrl & wr_data[0];

  // Only addr[1:0] and wr_data[11:0] carry meaning.
  logic w_unused;
  assign w_unused = &{1'b0, addr[13:2], wr_data[31:12]};

  // Frame tick: rising edge of "at pixel (0,0)".
  logic w_at_origin;
  logic w_tick;
  assign w_at_origin = (x == 11'd0) && (y == 11'd0);
  assign w_tick      = w_at_origin & ~r_origin_d;

  // Step and hold-exit conditions use >= so that a register lowered below the
  // running count forces the transition on the next tick instead of wrapping.
  logic [7:0] w_period_eff;
  logic       w_step_due;
  logic [8:0] w_hcnt_inc;
  logic       w_hold_done;
  logic       w_loop;

  assign w_period_eff = (r_period == 8'd0) ? 8'd1 : r_period;
  assign w_step_due   = (r_fcnt >= (w_period_eff - 8'd1));
  assign w_hcnt_inc   = {1'b0, r_hcnt} + 9'd1;
  assign w_hold_done  = (w_hcnt_inc >= {1'b0, r_hold});
`ifdef VGA_FADE_LOOP_EN
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // Register file writes; a write coincident with a tick lands at the same
  // edge, so the sequencer still sees the old value for that tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses <= so every register samples pre-edge values.
    if (reset) begin
      r_bypass <= 1'b0;
      r_period <= 8'(DEF_PERIOD);
      r_hold   <= 8'(DEF_HOLD);
      r_target <= 12'h000;
`ifdef VGA_FADE_LOOP_EN
      r_loop   <= 1'b0;
`endif
    end else begin
      if (w_wr_ctrl) begin
        r_bypass <= wr_data[1];
`ifdef VGA_FADE_LOOP_EN
        r_loop   <= wr_data[2];
`endif
      end
      if (w_wr_period) r_period <= wr_data[7:0];
      if (w_wr_hold)   r_hold   <= wr_data[7:0];
      if (w_wr_target) r_target <= wr_data[11:0];
    end
  end

  // Origin history for the tick edge detector.
  always_ff @(posedge clk) begin
    if (reset) r_origin_d <= 1'b0;
    else       r_origin_d <= w_at_origin;
  end

  // Fade sequencer: IDLE -> OUT -> HOLD -> IN -> IDLE (or OUT when looping).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_alpha <= 5'd16;
      r_fcnt  <= 8'd0;
      r_hcnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_alpha <= 5'd16;
          if (w_start) begin
            r_state <= S_OUT;
            r_fcnt  <= 8'd0;
          end
        end
        S_OUT: begin
          if (w_tick) begin
            if (w_step_due) begin
              r_fcnt <= 8'd0;
              if (r_alpha <= 5'd1) begin
                r_alpha <= 5'd0;
                r_state <= S_HOLD;
                r_hcnt  <= 8'd0;
              end else begin
                r_alpha <= r_alpha - 5'd1;
              end
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        S_HOLD: begin
          r_alpha <= 5'd0;
          if (w_tick) begin
            if (w_hold_done) begin
              r_state <= S_IN;
              r_fcnt  <= 8'd0;
            end else begin
              r_hcnt <= w_hcnt_inc[7:0];
            end
          end
        end
        S_IN: begin
          if (w_start) begin
            r_state <= S_OUT;
            r_fcnt  <= 8'd0;
          end else if (w_tick) begin
            if (w_step_due) begin
              r_fcnt <= 8'd0;
              if (r_alpha >= 5'd15) begin
                r_alpha <= 5'd16;
                r_state <= w_loop ? S_OUT : S_IDLE;
              end else begin
                r_alpha <= r_alpha + 5'd1;
              end
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_alpha <= 5'd16;
        end
      endcase
    end
  end

  // One 4-bit channel: (s*a + t*(16-a)) >> 4; the sum never exceeds 240.
  function automatic logic [3:0] mix(input logic [3:0] s, input logic [3:0] t,
                                     input logic [4:0] a);
    logic [8:0] p_s;
    logic [8:0] p_t;
    logic [8:0] sum;
    // NOTE: blocking = is correct here; this is pure combinational arithmetic.
    p_s = {5'd0, s} * {4'd0, a};
    p_t = {5'd0, t} * {4'd0, (5'd16 - a)};
    sum = p_s + p_t;
    return sum[7:4];
  endfunction

  logic [11:0] w_blend;
  assign w_blend = {mix(si_rgb[11:8], r_target[11:8], r_alpha),
                    mix(si_rgb[7:4],  r_target[7:4],  r_alpha),
                    mix(si_rgb[3:0],  r_target[3:0],  r_alpha)};

  // Output register: one clock of latency from si_rgb, like the other slots.
  always_ff @(posedge clk) begin
    if (reset) so_rgb <= '0;
    else       so_rgb <= r_bypass ? si_rgb : w_blend;
  end

endmodule
